// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use/RAW stall, branch flush and memory-wait freeze control with perf counters
module hazard_stall_ctrl #(
  parameter int REG_ADDR_LEN = 5,
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    forward_EN,
  input  logic [REG_ADDR_LEN-1:0] Rs_ID,
  input  logic [REG_ADDR_LEN-1:0] Rt_ID,
  input  logic                    two_src_ID,
  input  logic [REG_ADDR_LEN-1:0] EXE_Dest,
  input  logic                    EXE_WB_EN,
  input  logic                    EXE_MEM_R_EN,
  input  logic [REG_ADDR_LEN-1:0] MEM_Dest,
  input  logic                    MEM_WB_EN,
  input  logic                    Br_taken_EXE,
  input  logic                    mem_req_MEM,
  input  logic                    mem_ready,
  output logic                    freeze_PC,
  output logic                    freeze_IF_ID,
  output logic                    bubble_ID_EXE,
  output logic                    flush_IF_ID,
  output logic                    freeze_pipe,
  output logic                    mem_timeout,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(TIMEOUT);
  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;
  state_t state;
  logic [WW-1:0] wait_ctr;
  logic timeout_q, m_exe, m_mem, haz, mwait, do_flush, do_stall;
  // register 0 is hardwired, so it can never be a hazard source
  assign m_exe = |EXE_Dest && (Rs_ID == EXE_Dest || (two_src_ID && Rt_ID == EXE_Dest));
  assign m_mem = |MEM_Dest && (Rs_ID == MEM_Dest || (two_src_ID && Rt_ID == MEM_Dest));
  // with forwarding only a load in EXE can't be bypassed; without it every in-flight writer stalls
  assign haz = forward_EN ? EXE_MEM_R_EN && m_exe : (EXE_WB_EN && m_exe) || (MEM_WB_EN && m_mem);
  // a ready response in WAIT releases the freeze in the same cycle
  assign mwait = state == ERR || (state == WAIT ? !mem_ready : mem_req_MEM && !mem_ready);
  assign do_flush = !rst && !mwait && Br_taken_EXE;
  assign do_stall = !rst && !mwait && !Br_taken_EXE && haz;
  assign freeze_pipe = !rst && mwait;
  assign flush_IF_ID = do_flush;
  assign bubble_ID_EXE = do_flush || do_stall;
  assign freeze_PC = do_stall;
  assign freeze_IF_ID = do_stall;
  assign mem_timeout = timeout_q && !rst;
  // memory-wait tracker: counts consecutive wait cycles and latches a stuck memory as an error
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      wait_ctr <= '0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state)
        RUN: if (mem_req_MEM && !mem_ready) begin
          state <= WAIT;
          wait_ctr <= WW'(1);
        end
        WAIT: if (mem_ready) begin
          state <= RUN;
          wait_ctr <= '0;
        end else if (wait_ctr == TMO) begin
          state <= ERR;
          timeout_q <= 1'b1;
        end else begin
          wait_ctr <= wait_ctr + 1'b1;
        end
        ERR: state <= ERR;
        default: state <= RUN;
      endcase
    end
  end
  // saturating performance counters for hazard stalls and branch flushes
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= do_stall && !(&stall_cnt) ? stall_cnt + 1'b1 : stall_cnt;
      flush_cnt <= do_flush && !(&flush_cnt) ? flush_cnt + 1'b1 : flush_cnt;
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: vector table, directed corner sequences and randomized model comparison
module tb_hazard_stall_ctrl;
  localparam int TMO = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 0, rst = 1;
  logic forward_EN = 1, two_src_ID = 0, EXE_WB_EN = 0, EXE_MEM_R_EN = 0, MEM_WB_EN = 0;
  logic Br_taken_EXE = 0, mem_req_MEM = 0, mem_ready = 1;
  logic [4:0] Rs_ID = 0, Rt_ID = 0, EXE_Dest = 0, MEM_Dest = 0;
  logic freeze_PC, freeze_IF_ID, bubble_ID_EXE, flush_IF_ID, freeze_pipe, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [4:0] ctl;
  int checks = 0, errors = 0;
  int m_w, m_scnt, m_fcnt;
  bit m_err;
  typedef struct {
    int fe, rs, rt, two, ed, ewb, eld, md, mwb, br, req, rdy, exp;
  } vec_t;
  vec_t vt[14];

  hazard_stall_ctrl #(.REG_ADDR_LEN(5), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .forward_EN(forward_EN), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .two_src_ID(two_src_ID), .EXE_Dest(EXE_Dest), .EXE_WB_EN(EXE_WB_EN),
    .EXE_MEM_R_EN(EXE_MEM_R_EN), .MEM_Dest(MEM_Dest), .MEM_WB_EN(MEM_WB_EN),
    .Br_taken_EXE(Br_taken_EXE), .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
    .freeze_PC(freeze_PC), .freeze_IF_ID(freeze_IF_ID), .bubble_ID_EXE(bubble_ID_EXE),
    .flush_IF_ID(flush_IF_ID), .freeze_pipe(freeze_pipe), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctl = {freeze_PC, freeze_IF_ID, bubble_ID_EXE, flush_IF_ID, freeze_pipe};
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    forward_EN = v.fe[0]; Rs_ID = v.rs[4:0]; Rt_ID = v.rt[4:0]; two_src_ID = v.two[0];
    EXE_Dest = v.ed[4:0]; EXE_WB_EN = v.ewb[0]; EXE_MEM_R_EN = v.eld[0];
    MEM_Dest = v.md[4:0]; MEM_WB_EN = v.mwb[0]; Br_taken_EXE = v.br[0];
    mem_req_MEM = v.req[0]; mem_ready = v.rdy[0];
  endtask

  task automatic idle();
    apply('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0});
  endtask

  task automatic load_use(input bit fe);
    forward_EN = fe; Rs_ID = 2; Rt_ID = 4; two_src_ID = 1;
    EXE_Dest = 2; EXE_WB_EN = 1; EXE_MEM_R_EN = fe;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle();
    #1 chk("rst_ctl", 32'(ctl), 0);
    chk("rst_timeout", 32'(mem_timeout), 0);
    @(negedge clk);
    #1 chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
    rst = 0;
  endtask

  function automatic bit mm(input logic [4:0] d);
    return d != 0 && (Rs_ID == d || (two_src_ID && Rt_ID == d));
  endfunction

  function automatic bit m_mwait();
    return m_err || (m_w > 0 ? !mem_ready : mem_req_MEM && !mem_ready);
  endfunction

  function automatic logic [4:0] m_ctl();
    bit haz;
    haz = forward_EN ? EXE_MEM_R_EN && mm(EXE_Dest)
                     : (EXE_WB_EN && mm(EXE_Dest)) || (MEM_WB_EN && mm(MEM_Dest));
    if (rst) return 5'b00000;
    if (m_mwait()) return 5'b00001;
    if (Br_taken_EXE) return 5'b00110;
    if (haz) return 5'b11100;
    return 5'b00000;
  endfunction

  task automatic m_step();
    logic [4:0] c;
    bit mw;
    c = m_ctl();
    mw = m_mwait();
    if (rst) begin
      m_w = 0; m_err = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (mw && !m_err) begin
        if (m_w + 1 > TMO) m_err = 1;
        else m_w = m_w + 1;
      end else if (!mw) m_w = 0;
      if (c == 5'b00110) m_fcnt = m_fcnt < CMAX ? m_fcnt + 1 : CMAX;
      if (c == 5'b11100) m_scnt = m_scnt < CMAX ? m_scnt + 1 : CMAX;
    end
  endtask

  initial begin
    // fe rs rt two ed ewb eld md mwb br req rdy exp{fPC,fIFID,bub,flush,fpipe}
    vt[0]  = '{1, 2, 4, 1, 2, 1, 1, 0, 0, 0, 0, 1, 'b11100};
    vt[1]  = '{1, 2, 4, 1, 2, 1, 0, 0, 0, 0, 0, 1, 'b00000};
    vt[2]  = '{1, 3, 2, 1, 2, 1, 1, 0, 0, 0, 0, 1, 'b11100};
    vt[3]  = '{1, 3, 2, 0, 2, 1, 1, 0, 0, 0, 0, 1, 'b00000};
    vt[4]  = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 'b00000};
    vt[5]  = '{0, 2, 4, 0, 2, 1, 0, 0, 0, 0, 0, 1, 'b11100};
    vt[6]  = '{0, 5, 7, 1, 1, 1, 0, 7, 1, 0, 0, 1, 'b11100};
    vt[7]  = '{0, 5, 0, 0, 5, 0, 0, 5, 0, 0, 0, 1, 'b00000};
    vt[8]  = '{1, 5, 0, 0, 0, 0, 0, 5, 1, 0, 0, 1, 'b00000};
    vt[9]  = '{1, 2, 4, 1, 2, 1, 1, 0, 0, 1, 0, 1, 'b00110};
    vt[10] = '{1, 6, 6, 1, 0, 0, 0, 0, 0, 1, 0, 1, 'b00110};
    vt[11] = '{1, 2, 4, 1, 2, 1, 1, 0, 0, 1, 1, 0, 'b00001};
    vt[12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'b00000};
    vt[13] = '{1, 2, 4, 1, 2, 1, 1, 0, 0, 0, 1, 1, 'b11100};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      apply(vt[i]);
      #1 chk($sformatf("vec%0d", i), 32'(ctl), vt[i].exp);
    end
    // single-cycle load-use stall with forwarding
    do_reset();
    @(negedge clk); load_use(1);
    #1 chk("lu_ctl", 32'(ctl), 'b11100);
    @(negedge clk); idle();
    #1 chk("lu_stall_cnt", 32'(stall_cnt), 1);
    // no forwarding: producer walks EXE then MEM, then a $0 writer
    do_reset();
    @(negedge clk); load_use(0);
    #1 chk("nf_exe_ctl", 32'(ctl), 'b11100);
    @(negedge clk); EXE_Dest = 0; EXE_WB_EN = 0; MEM_Dest = 2; MEM_WB_EN = 1;
    #1 chk("nf_mem_ctl", 32'(ctl), 'b11100);
    @(negedge clk); idle(); forward_EN = 0; two_src_ID = 1; EXE_WB_EN = 1; MEM_WB_EN = 1;
    #1 chk("nf_r0_ctl", 32'(ctl), 0);
    chk("nf_stall_cnt", 32'(stall_cnt), 2);
    @(negedge clk); idle();
    #1 chk("nf_stall_cnt2", 32'(stall_cnt), 2);
    // branch beats load-use
    do_reset();
    @(negedge clk); load_use(1); Br_taken_EXE = 1;
    #1 chk("br_ctl", 32'(ctl), 'b00110);
    @(negedge clk); idle();
    #1 chk("br_flush_cnt", 32'(flush_cnt), 1);
    chk("br_stall_cnt", 32'(stall_cnt), 0);
    // three-cycle memory wait with a coincident hazard
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); load_use(1); mem_req_MEM = 1; mem_ready = 0;
      #1 chk($sformatf("mw_ctl%0d", i), 32'(ctl), 'b00001);
    end
    @(negedge clk); idle(); mem_req_MEM = 1;
    #1 chk("mw_release", 32'(ctl), 0);
    @(negedge clk); idle();
    #1 chk("mw_stall_cnt", 32'(stall_cnt), 0);
    chk("mw_flush_cnt", 32'(flush_cnt), 0);
    // stuck memory escalates to a sticky timeout, cleared only by reset
    do_reset();
    for (int i = 1; i <= TMO + 1; i++) begin
      @(negedge clk); idle(); mem_req_MEM = 1; mem_ready = 0;
      #1 chk($sformatf("to_ctl%0d", i), 32'(ctl), 'b00001);
      chk($sformatf("to_flag%0d", i), 32'(mem_timeout), 0);
    end
    @(negedge clk);
    #1 chk("to_flag_set", 32'(mem_timeout), 1);
    chk("to_ctl_err", 32'(ctl), 'b00001);
    @(negedge clk); mem_ready = 1; Br_taken_EXE = 1;
    #1 chk("to_err_absorb", 32'(ctl), 'b00001);
    chk("to_flag_sticky", 32'(mem_timeout), 1);
    do_reset();
    #1 chk("to_cleared", 32'(mem_timeout), 0);
    chk("to_ctl_cleared", 32'(ctl), 0);
    // stall counter saturation
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); load_use(1);
      #1 if (i == 16) chk("sat_cnt16", 32'(stall_cnt), 15);
    end
    @(negedge clk); idle();
    #1 chk("sat_hold", 32'(stall_cnt), 15);
    // randomized comparison against the behavioural model
    do_reset();
    m_w = 0; m_err = 0; m_scnt = 0; m_fcnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rst = $urandom_range(0, 49) == 0;
      forward_EN = 1'($urandom_range(0, 1));
      Rs_ID = 5'($urandom_range(0, 3)); Rt_ID = 5'($urandom_range(0, 3));
      two_src_ID = 1'($urandom_range(0, 1));
      EXE_Dest = 5'($urandom_range(0, 3)); MEM_Dest = 5'($urandom_range(0, 3));
      EXE_WB_EN = 1'($urandom_range(0, 1)); EXE_MEM_R_EN = 1'($urandom_range(0, 1));
      MEM_WB_EN = 1'($urandom_range(0, 1));
      Br_taken_EXE = $urandom_range(0, 5) == 0;
      mem_req_MEM = $urandom_range(0, 2) == 0;
      mem_ready = $urandom_range(0, 99) < 60;
      #1 chk($sformatf("rnd_ctl%0d", i), 32'(ctl), 32'(m_ctl()));
      chk($sformatf("rnd_to%0d", i), 32'(mem_timeout), 32'(!rst && m_err));
      chk($sformatf("rnd_scnt%0d", i), 32'(stall_cnt), 32'(m_scnt));
      chk($sformatf("rnd_fcnt%0d", i), 32'(flush_cnt), 32'(m_fcnt));
      m_step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
